// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and destination scoreboard for the four register-file
// write ports (arithmetic, logic, shift0, shift1). Each execution unit feeds a
// private FIFO through a valid/ready handshake. Same-address heads are resolved
// by a rotating priority pointer so no write is ever silently lost.
module rf_wb_arbiter #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                clk_i,
    input  logic                                arst_n_i,
    input  logic                                flush_i,
    input  logic [3:0]                          req_valid_i,
    output logic [3:0]                          req_ready_o,
    input  logic [3:0][ADDRESS_WIDTH-1:0]       req_addr_i,
    input  logic [3:0][WORD_WIDTH-1:0]          req_data_i,
    output logic [3:0][ADDRESS_WIDTH-1:0]       select_r_o,
    output logic [3:0][WORD_WIDTH-1:0]          data_o,
    output logic [3:0]                          enable_writing_o,
    output logic [(2**ADDRESS_WIDTH)-1:0]       busy_o,
    output logic                                error_o,
    output logic                                idle_o
);

    localparam int UNITS = 2**ADDRESS_WIDTH;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    // Addresses 0..2 (main input, instruction input, flags) are read-only.
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_WRITABLE = ADDRESS_WIDTH'(3);
    localparam logic [CW-1:0]            DEPTH_C        = CW'(FIFO_DEPTH);

    // FIFO storage (no reset needed: contents are only observed when counted valid)
    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [4][FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]    fifo_data_q [4][FIFO_DEPTH];

    // FIFO control and arbitration state
    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] rd_ptr_d [4];
    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] wr_ptr_d [4];
    logic [CW-1:0] count_q  [4];
    logic [CW-1:0] count_d  [4];
    logic [1:0]    prio_q;
    logic [1:0]    prio_d;
    logic          error_q;
    logic          error_d;

    // Combinational views of the heads and arbitration result
    logic [3:0]                    cand;
    logic [3:0]                    issue;
    logic [3:0]                    collide;
    logic [3:0]                    push;
    logic [3:0]                    pop;
    logic [3:0][ADDRESS_WIDTH-1:0] head_addr;
    logic [3:0][WORD_WIDTH-1:0]    head_data;
    logic                          any_coll;
    logic [1:0]                    top_win;
    logic                          ro_hit;

    // Head extraction and candidate flags from registered FIFO state
    always_comb begin
        cand      = '0;
        head_addr = '0;
        head_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand[i]      = (count_q[i] != '0);
            head_addr[i] = fifo_addr_q[i][rd_ptr_q[i]];
            head_data[i] = fifo_data_q[i][rd_ptr_q[i]];
        end
    end

    // Rotating-priority arbitration: a candidate loses only to a same-address
    // candidate that sits closer to the priority pointer (distance mod 4).
    always_comb begin
        logic [1:0] di;
        logic [1:0] dj;
        issue    = '0;
        collide  = '0;
        any_coll = 1'b0;
        top_win  = '0;
        di       = '0;
        dj       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            issue[i] = cand[i];
            di       = 2'(i) - prio_q;
            for (int unsigned j = 0; j < 4; j++) begin
                dj = 2'(j) - prio_q;
                if ((j != i) && cand[i] && cand[j] && (head_addr[j] == head_addr[i])) begin
                    collide[i] = 1'b1;
                    if (dj < di) begin
                        issue[i] = 1'b0;
                    end
                end
            end
        end
        // Highest-index winner among colliding groups sets the next pointer
        for (int unsigned i = 0; i < 4; i++) begin
            if (issue[i] && collide[i]) begin
                any_coll = 1'b1;
                top_win  = 2'(i);
            end
        end
    end

    // Handshake, push/pop qualification and register-file drive
    always_comb begin
        req_ready_o      = '0;
        push             = '0;
        ro_hit           = 1'b0;
        select_r_o       = '0;
        data_o           = '0;
        enable_writing_o = '0;
        pop              = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            req_ready_o[i] = (count_q[i] < DEPTH_C);
            if (req_valid_i[i] && req_ready_o[i] && !flush_i) begin
                if (req_addr_i[i] >= FIRST_WRITABLE) begin
                    push[i] = 1'b1;
                end else begin
                    ro_hit = 1'b1;
                end
            end
            if (cand[i]) begin
                select_r_o[i] = head_addr[i];
                data_o[i]     = head_data[i];
            end
            enable_writing_o[i] = issue[i] && !flush_i;
            pop[i]              = issue[i] && !flush_i;
        end
    end

    // Next-state for pointers, counts, priority and error pulse
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            if (flush_i) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end
        prio_d = prio_q;
        if (flush_i) begin
            prio_d = '0;
        end else if (any_coll) begin
            prio_d = top_win + 2'd1;
        end
        error_d = ro_hit;
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            prio_q  <= '0;
            error_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            prio_q  <= prio_d;
            error_q <= error_d;
        end
    end

    // FIFO storage writes on accepted, writable transfers
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (push[i]) begin
                fifo_addr_q[i][wr_ptr_q[i]] <= req_addr_i[i];
                fifo_data_q[i][wr_ptr_q[i]] <= req_data_i[i];
            end
        end
    end

    // Scoreboard: mark every address targeted by a counted-valid FIFO slot
    always_comb begin
        logic [PW-1:0] off;
        busy_o = '0;
        off    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                off = PW'(k) - rd_ptr_q[i];
                if (CW'(off) < count_q[i]) begin
                    busy_o[fifo_addr_q[i][k]] = 1'b1;
                end
            end
        end
    end

    // Status outputs from registered state
    always_comb begin
        idle_o = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (count_q[i] != '0) begin
                idle_o = 1'b0;
            end
        end
        error_o = error_q;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

    localparam int WW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int UNITS = 8;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [3:0]           valid = '0;
    logic [3:0]           ready;
    logic [3:0][AW-1:0]   addr = '0;
    logic [3:0][WW-1:0]   data = '0;
    logic [3:0][AW-1:0]   select_r;
    logic [3:0][WW-1:0]   wdata;
    logic [3:0]           enable;
    logic [UNITS-1:0]     busy;
    logic                 error;
    logic                 idle;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .WORD_WIDTH   (WW),
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i           (clk),
        .arst_n_i        (arst_n),
        .flush_i         (flush),
        .req_valid_i     (valid),
        .req_ready_o     (ready),
        .req_addr_i      (addr),
        .req_data_i      (data),
        .select_r_o      (select_r),
        .data_o          (wdata),
        .enable_writing_o(enable),
        .busy_o          (busy),
        .error_o         (error),
        .idle_o          (idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue of (addr, data) per requester
    int       qa [4][$];
    int       qd [4][$];
    int       m_ptr;
    bit       m_err;
    bit [3:0] m_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            qa[i].delete();
            qd[i].delete();
        end
        m_ptr  = 0;
        m_err  = 0;
        m_hold = '0;
    endtask

    // Winner per address group: first candidate met scanning ptr, ptr+1, ...
    function automatic void model_arb(output bit [3:0] win, output bit coll, output int top);
        win  = '0;
        coll = 0;
        top  = 0;
        for (int i = 0; i < 4; i++) begin
            if (qa[i].size() > 0) begin
                int first;
                int grp;
                first = -1;
                grp   = 0;
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (qa[j].size() > 0 && qa[j][0] == qa[i][0]) begin
                        grp++;
                        if (first < 0) first = j;
                    end
                end
                win[i] = (first == i);
                if (grp > 1 && win[i]) begin
                    coll = 1;
                    if (i > top) top = i;
                end
            end
        end
    endfunction

    task automatic compare_all();
        bit [3:0]         win;
        bit               coll;
        int               top;
        logic [UNITS-1:0] e_busy;
        bit               e_idle;
        model_arb(win, coll, top);
        e_busy = '0;
        e_idle = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ready%0d", i), ready[i], qa[i].size() < DEPTH);
            check($sformatf("enable%0d", i), enable[i], win[i] && !flush);
            check($sformatf("select%0d", i), select_r[i], qa[i].size() > 0 ? qa[i][0] : 0);
            check($sformatf("data%0d", i), wdata[i], qd[i].size() > 0 ? qd[i][0] : 0);
            foreach (qa[i][k]) e_busy[qa[i][k]] = 1'b1;
            if (qa[i].size() > 0) e_idle = 0;
        end
        check("busy", busy, e_busy);
        check("idle", idle, e_idle);
        check("error", error, m_err);
    endtask

    task automatic model_step();
        bit [3:0] win;
        bit       coll;
        int       top;
        bit [3:0] rdy;
        model_arb(win, coll, top);
        for (int i = 0; i < 4; i++) rdy[i] = qa[i].size() < DEPTH;
        m_err = 0;
        if (flush) begin
            for (int i = 0; i < 4; i++) begin
                qa[i].delete();
                qd[i].delete();
            end
            m_ptr = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (win[i]) begin
                    void'(qa[i].pop_front());
                    void'(qd[i].pop_front());
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && rdy[i]) begin
                    if (addr[i] >= 3) begin
                        qa[i].push_back(int'(addr[i]));
                        qd[i].push_back(int'(data[i]));
                    end else begin
                        m_err = 1;
                    end
                end
            end
            if (coll) m_ptr = (top + 1) % 4;
        end
        for (int i = 0; i < 4; i++) m_hold[i] = valid[i] && !rdy[i];
    endtask

    // Called at a falling edge with inputs already driven
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        int n1_issued;
        bit saw_block;
        model_reset();

        // Reset then idle
        repeat (2) @(negedge clk);
        #1;
        check("rst_enable", enable, 4'h0);
        check("rst_busy", busy, '0);
        check("rst_ready", ready, 4'hF);
        check("rst_idle", idle, 1'b1);
        check("rst_error", error, 1'b0);
        check("rst_select", select_r, '0);
        check("rst_data", wdata, '0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // Single write
        valid[0] = 1'b1; addr[0] = 3'd5; data[0] = 16'h1234;
        tick();
        valid = '0;
        #1;
        check("single_enable", enable, 4'b0001);
        check("single_select", select_r[0], 3'd5);
        check("single_data", wdata[0], 16'h1234);
        check("single_busy5", busy[5], 1'b1);
        tick();
        #1;
        check("single_idle_after", idle, 1'b1);
        check("single_busy_after", busy, '0);
        tick();

        // Collision rotation: four writes to address 4
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b1; addr[i] = 3'd4; data[i] = WW'(i + 1);
        end
        tick();
        valid = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rot_enable_c%0d", k), enable, 4'b0001 << k);
            check($sformatf("rot_data_c%0d", k), wdata[k], k + 1);
            tick();
        end

        // Disjoint parallel writes
        addr[0] = 3'd4; addr[1] = 3'd5; addr[2] = 3'd6; addr[3] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b1; data[i] = WW'(16'hA0 + i);
        end
        tick();
        valid = '0;
        #1;
        check("disjoint_enable", enable, 4'hF);
        tick();
        tick();

        // Backpressure: req1 pushes three writes while req0 keeps colliding
        accepted  = 0;
        n1_issued = 0;
        saw_block = 0;
        for (int c = 0; c < 40 && (accepted < 3 || !idle); c++) begin
            valid[0] = (c < 12);
            addr[0]  = 3'd4;
            data[0]  = WW'($urandom);
            valid[1] = (accepted < 3);
            addr[1]  = 3'd4;
            data[1]  = WW'(16'hB0 + accepted);
            #1;
            if (!ready[1]) saw_block = 1;
            if (enable[1]) n1_issued++;
            if (valid[1] && qa[1].size() < DEPTH) accepted++;
            #0;
            tick();
        end
        valid = '0;
        check("bp_ready_low_seen", saw_block, 1'b1);
        check("bp_req1_issued", n1_issued, 3);
        tick();

        // Read-only write raises a single error pulse
        valid[2] = 1'b1; addr[2] = 3'd1; data[2] = 16'hDEAD;
        tick();
        valid = '0;
        #1;
        check("ro_error", error, 1'b1);
        check("ro_enable", enable, 4'h0);
        tick();
        #1;
        check("ro_error_cleared", error, 1'b0);
        tick();

        // Flush discards queued writes
        valid[0] = 1'b1; addr[0] = 3'd5; data[0] = 16'h5555;
        valid[1] = 1'b1; addr[1] = 3'd6; data[1] = 16'h6666;
        tick();
        valid = '0;
        flush = 1'b1;
        #1;
        check("flush_enable", enable, 4'h0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", idle, 1'b1);
        check("flush_busy", busy, '0);
        check("flush_enable_after", enable, 4'h0);
        tick();

        // Asynchronous reset mid-operation
        valid[3] = 1'b1; addr[3] = 3'd7; data[3] = 16'h7777;
        valid[2] = 1'b1; addr[2] = 3'd7; data[2] = 16'h2727;
        tick();
        valid = '0;
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_enable", enable, 4'h0);
        check("arst_idle", idle, 1'b1);
        check("arst_ready", ready, 4'hF);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!m_hold[i]) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    addr[i]  = AW'($urandom_range(0, 9) < 8 ? $urandom_range(3, 7) : $urandom_range(0, 2));
                    data[i]  = WW'($urandom);
                end
            end
            tick();
        end
        flush = 1'b0;
        valid = '0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
